// File: rtl/get_motion_code_dec_if.sv
`default_nettype none
// ============================================================================
// Module      : get_motion_code_dec_if
// Description : Request/result bundle between the bitstream flush buffer and
//               the motion_code VLC decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface get_motion_code_dec_if;
    // buf_win[10] is the first (oldest) bit of the VLC
    logic [10:0] buf_win;
    logic        in_valid;
    logic [4:0]  outshift;
    logic [4:0]  mcode;
    logic        msign;
    logic        error;
    logic        done;

    modport master (
        output buf_win,
        output in_valid,
        input  outshift,
        input  mcode,
        input  msign,
        input  error,
        input  done
    );

    modport slave (
        input  buf_win,
        input  in_valid,
        output outshift,
        output mcode,
        output msign,
        output error,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/get_motion_code_dec.sv
`default_nettype none
// ============================================================================
// Module      : get_motion_code_dec
// Description : MPEG-2 motion_code VLC decoder (Table B-10, sign included),
//               one combinational lookup with registered results.
// Revision    : 1.0 - initial release
// ============================================================================
module get_motion_code_dec (
    input  wire                        clk,
    input  wire                        rst,
    get_motion_code_dec_if.slave       bus
);

    logic [4:0] w_mag;
    logic [4:0] w_len;
    logic       w_sign;
    logic       w_err;
    logic [4:0] w_mcode;

    logic [4:0] r_outshift;
    logic [4:0] r_mcode;
    logic       r_msign;
    logic       r_error;
    logic       r_done;

    // Sign bit sits right after the prefix, i.e. at buf_win[11-L].
    always_comb begin
        w_mag  = 5'd0;
        w_len  = 5'd0;
        w_sign = 1'b0;
        w_err  = 1'b0;
        casez (bus.buf_win)
            11'b1??????????: begin w_mag = 5'd0;  w_len = 5'd1;  end
            11'b01?????????: begin w_mag = 5'd1;  w_len = 5'd3;  w_sign = bus.buf_win[8]; end
            11'b001????????: begin w_mag = 5'd2;  w_len = 5'd4;  w_sign = bus.buf_win[7]; end
            11'b0001???????: begin w_mag = 5'd3;  w_len = 5'd5;  w_sign = bus.buf_win[6]; end
            11'b000011?????: begin w_mag = 5'd4;  w_len = 5'd7;  w_sign = bus.buf_win[4]; end
            11'b0000101????: begin w_mag = 5'd5;  w_len = 5'd8;  w_sign = bus.buf_win[3]; end
            11'b0000100????: begin w_mag = 5'd6;  w_len = 5'd8;  w_sign = bus.buf_win[3]; end
            11'b0000011????: begin w_mag = 5'd7;  w_len = 5'd8;  w_sign = bus.buf_win[3]; end
            11'b000001011??: begin w_mag = 5'd8;  w_len = 5'd10; w_sign = bus.buf_win[1]; end
            11'b000001010??: begin w_mag = 5'd9;  w_len = 5'd10; w_sign = bus.buf_win[1]; end
            11'b000001001??: begin w_mag = 5'd10; w_len = 5'd10; w_sign = bus.buf_win[1]; end
            11'b0000010001?: begin w_mag = 5'd11; w_len = 5'd11; w_sign = bus.buf_win[0]; end
            11'b0000010000?: begin w_mag = 5'd12; w_len = 5'd11; w_sign = bus.buf_win[0]; end
            11'b0000001111?: begin w_mag = 5'd13; w_len = 5'd11; w_sign = bus.buf_win[0]; end
            11'b0000001110?: begin w_mag = 5'd14; w_len = 5'd11; w_sign = bus.buf_win[0]; end
            11'b0000001101?: begin w_mag = 5'd15; w_len = 5'd11; w_sign = bus.buf_win[0]; end
            11'b0000001100?: begin w_mag = 5'd16; w_len = 5'd11; w_sign = bus.buf_win[0]; end
            default:         begin w_err = 1'b1; end
        endcase
    end

    // Magnitude 16 wraps to 5'b10000 for either sign; msign tells them apart.
    assign w_mcode = w_sign ? (~w_mag + 5'd1) : w_mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outshift <= 5'd0;
            r_mcode    <= 5'd0;
            r_msign    <= 1'b0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
        end else if (bus.in_valid) begin
            r_outshift <= w_len;
            r_mcode    <= w_mcode;
            r_msign    <= w_sign;
            r_error    <= w_err;
            r_done     <= 1'b1;
        end else begin
            r_done     <= 1'b0;
        end
    end

    assign bus.outshift = r_outshift;
    assign bus.mcode    = r_mcode;
    assign bus.msign    = r_msign;
    assign bus.error    = r_error;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_get_motion_code_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_get_motion_code_dec
// Description : Directed table-driven bench for the motion_code VLC decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_get_motion_code_dec;

    typedef struct {
        logic [10:0] b;
        logic [4:0]  shift;
        logic [4:0]  mcode;
        logic        msign;
        logic        err;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl [27];

    get_motion_code_dec_if bus ();

    get_motion_code_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic done, input logic err,
                         input logic [4:0] shift, input logic [4:0] mc, input logic ms);
        checks++;
        if (bus.done !== done || bus.error !== err || bus.outshift !== shift ||
            bus.mcode !== mc || bus.msign !== ms) begin
            errors++;
            $display("FAIL %s: got done=%b err=%b shift=%0d mcode=%b msign=%b, want done=%b err=%b shift=%0d mcode=%b msign=%b",
                     name, bus.done, bus.error, bus.outshift, bus.mcode, bus.msign,
                     done, err, shift, mc, ms);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //              buf             shift  mcode     sign err
        tbl[0]  = '{11'b10101010101, 5'd1,  5'b00000, 1'b0, 1'b0};
        tbl[1]  = '{11'b11111111111, 5'd1,  5'b00000, 1'b0, 1'b0};
        tbl[2]  = '{11'b01011111111, 5'd3,  5'b00001, 1'b0, 1'b0};
        tbl[3]  = '{11'b01100000000, 5'd3,  5'b11111, 1'b1, 1'b0};
        tbl[4]  = '{11'b00101010101, 5'd4,  5'b00010, 1'b0, 1'b0};
        tbl[5]  = '{11'b00110000000, 5'd4,  5'b11110, 1'b1, 1'b0};
        tbl[6]  = '{11'b00010111111, 5'd5,  5'b00011, 1'b0, 1'b0};
        tbl[7]  = '{11'b00011000000, 5'd5,  5'b11101, 1'b1, 1'b0};
        tbl[8]  = '{11'b00001101111, 5'd7,  5'b00100, 1'b0, 1'b0};
        tbl[9]  = '{11'b00001110000, 5'd7,  5'b11100, 1'b1, 1'b0};
        tbl[10] = '{11'b00001010111, 5'd8,  5'b00101, 1'b0, 1'b0};
        tbl[11] = '{11'b00001001101, 5'd8,  5'b11010, 1'b1, 1'b0};
        tbl[12] = '{11'b00000110000, 5'd8,  5'b00111, 1'b0, 1'b0};
        tbl[13] = '{11'b00000111111, 5'd8,  5'b11001, 1'b1, 1'b0};
        tbl[14] = '{11'b00000101101, 5'd10, 5'b01000, 1'b0, 1'b0};
        tbl[15] = '{11'b00000101010, 5'd10, 5'b10111, 1'b1, 1'b0};
        tbl[16] = '{11'b00000100101, 5'd10, 5'b01010, 1'b0, 1'b0};
        tbl[17] = '{11'b00000100011, 5'd11, 5'b10101, 1'b1, 1'b0};
        tbl[18] = '{11'b00000100000, 5'd11, 5'b01100, 1'b0, 1'b0};
        tbl[19] = '{11'b00000011110, 5'd11, 5'b01101, 1'b0, 1'b0};
        tbl[20] = '{11'b00000011101, 5'd11, 5'b10010, 1'b1, 1'b0};
        tbl[21] = '{11'b00000011010, 5'd11, 5'b01111, 1'b0, 1'b0};
        tbl[22] = '{11'b00000011001, 5'd11, 5'b10000, 1'b1, 1'b0};
        tbl[23] = '{11'b00000011000, 5'd11, 5'b10000, 1'b0, 1'b0};
        tbl[24] = '{11'b00000010101, 5'd0,  5'b00000, 1'b0, 1'b1};
        tbl[25] = '{11'b00000001111, 5'd0,  5'b00000, 1'b0, 1'b1};
        tbl[26] = '{11'b00000000000, 5'd0,  5'b00000, 1'b0, 1'b1};

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.buf_win  = 11'd0;
        #2;
        check("reset", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(posedge clk);
        #1;
        check("idle_after_reset", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

        // in_valid stays high across the whole table: back-to-back re-decode.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.buf_win = tbl[i].b;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 1'b1, tbl[i].err, tbl[i].shift,
                  tbl[i].mcode, tbl[i].msign);
        end

        // Error result then drop in_valid: done falls, fields hold.
        bus.in_valid = 1'b0;
        bus.buf_win  = 11'b10000000000;
        @(posedge clk);
        #1;
        check("hold_after_error", 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_second_cycle", 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);

        // Non-error result then idle hold.
        bus.in_valid = 1'b1;
        bus.buf_win  = 11'b00001001000;
        @(posedge clk);
        #1;
        check("minus6", 1'b1, 1'b0, 5'd8, 5'b11010, 1'b1);
        bus.in_valid = 1'b0;
        bus.buf_win  = 11'b01000000000;
        @(posedge clk);
        #1;
        check("hold_minus6", 1'b0, 1'b0, 5'd8, 5'b11010, 1'b1);

        // Mid-stream asynchronous reset, observed without a clock edge.
        bus.in_valid = 1'b1;
        bus.buf_win  = 11'b01100000000;
        @(posedge clk);
        #1;
        check("pre_reset", 1'b1, 1'b0, 5'd3, 5'b11111, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_reset", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        rst = 1'b1;
        bus.buf_win = 11'b00000011001;
        @(posedge clk);
        #1;
        check("restart", 1'b1, 1'b0, 5'd11, 5'b10000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
